// File: rtl/letc_core_pkg.sv
// Shared LETC core types: LIMP access size, physical address and data word.
package letc_core_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALFWORD = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_RSVD     = 2'b11
    } size_e;

    typedef logic [33:0] paddr_t;
    typedef logic [31:0] word_t;

    // Flattened width of one LIMP request payload: wen, uncacheable, size, addr, wdata.
    localparam int LIMP_PAYLOAD_W = 2 + $bits(size_e) + $bits(paddr_t) + $bits(word_t);

endpackage

// File: rtl/letc_core_limp_arbiter_if.sv
// LIMP arbiter bundle: NUM_REQ upstream requestor ports plus one downstream port.
// The arbiter uses the slave modport; the requestors/memory side uses master.
interface letc_core_limp_arbiter_if
    import letc_core_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic  [NUM_REQ-1:0] i_req_valid;
    logic  [NUM_REQ-1:0] o_req_ready;
    logic  [NUM_REQ-1:0] i_req_wen_nren;
    logic  [NUM_REQ-1:0] i_req_uncacheable;
    size_e [NUM_REQ-1:0] i_req_size;
    paddr_t [NUM_REQ-1:0] i_req_addr;
    word_t [NUM_REQ-1:0] i_req_wdata;
    word_t               o_req_rdata;

    logic                o_svc_valid;
    logic                i_svc_ready;
    logic                o_svc_wen_nren;
    logic                o_svc_uncacheable;
    size_e               o_svc_size;
    paddr_t              o_svc_addr;
    word_t               o_svc_wdata;
    word_t               i_svc_rdata;

    logic  [NUM_REQ-1:0] o_grant_onehot;

    modport slave (
        input  i_req_valid, i_req_wen_nren, i_req_uncacheable, i_req_size, i_req_addr, i_req_wdata,
        input  i_svc_ready, i_svc_rdata,
        output o_req_ready, o_req_rdata,
        output o_svc_valid, o_svc_wen_nren, o_svc_uncacheable, o_svc_size, o_svc_addr, o_svc_wdata,
        output o_grant_onehot
    );

    modport master (
        output i_req_valid, i_req_wen_nren, i_req_uncacheable, i_req_size, i_req_addr, i_req_wdata,
        output i_svc_ready, i_svc_rdata,
        input  o_req_ready, o_req_rdata,
        input  o_svc_valid, o_svc_wen_nren, o_svc_uncacheable, o_svc_size, o_svc_addr, o_svc_wdata,
        input  o_grant_onehot
    );

endinterface

// File: rtl/letc_core_limp_arbiter_chk.sv
// Simulation-only protocol checks for the LIMP arbiter outputs.
module letc_core_limp_arbiter_chk
    import letc_core_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input logic                      i_clk,
    input logic                      i_rst,
    input logic [NUM_REQ-1:0]        i_grant_onehot,
    input logic [NUM_REQ-1:0]        i_req_ready,
    input logic                      i_svc_valid,
    input logic                      i_svc_ready,
    input logic [LIMP_PAYLOAD_W-1:0] i_payload
);

    a_grant_onehot0: assert property (@(posedge i_clk) $onehot0(i_grant_onehot));

    a_ready_owner_only: assert property (@(posedge i_clk) (i_req_ready & ~i_grant_onehot) == '0);

    a_locked_transaction: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_svc_valid && !i_svc_ready) |=> ($stable(i_payload) && $stable(i_grant_onehot)));

endmodule

// File: rtl/letc_core_rr_picker.sv
// Round-robin pick: first set request bit after i_last, wrapping at NUM_REQ-1 to 0.
// i_last itself is checked last, so it only wins when nobody else is requesting.
module letc_core_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic               o_valid,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx
);
    localparam int unsigned NUM_U = NUM_REQ;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int unsigned offset);
        int unsigned sum_v;
        sum_v = 32'(base) + offset;
        if (sum_v >= NUM_U) begin
            sum_v = sum_v - NUM_U;
        end else begin
            sum_v = sum_v;
        end
        return IDX_W'(sum_v);
    endfunction

    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Scan candidates in rotation order; the first hit latches and masks later ones.
    always_comb begin
        o_valid  = 1'b0;
        o_onehot = '0;
        o_idx    = '0;
        cand_s   = '0;
        hit_s    = 1'b0;
        for (int unsigned off = 1; off <= NUM_U; off++) begin
            cand_s           = wrap_idx(i_last, off);
            hit_s            = !o_valid && i_req[cand_s];
            o_onehot[cand_s] = o_onehot[cand_s] | hit_s;
            o_idx            = hit_s ? cand_s : o_idx;
            o_valid          = o_valid | hit_s;
        end
    end

endmodule

// File: rtl/letc_core_limp_arbiter.sv
// LIMP N:1 arbiter: registers one owner per transaction (1-cycle arbitration) and
// re-grants round-robin on the handshake cycle so back-to-back traffic has no bubble.
module letc_core_limp_arbiter
    import letc_core_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    letc_core_limp_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;

    logic [NUM_REQ-1:0] owner_oh_s;
    logic               busy_s;
    logic               svc_valid_s;
    logic               handshake_s;
    logic [NUM_REQ-1:0] pick_req_s;
    logic [IDX_W-1:0]   pick_last_s;
    logic               pick_valid_s;
    logic [NUM_REQ-1:0] pick_onehot_s;
    logic [IDX_W-1:0]   pick_idx_s;

    assign owner_oh_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

    letc_core_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req    (pick_req_s),
        .i_last   (pick_last_s),
        .o_valid  (pick_valid_s),
        .o_onehot (pick_onehot_s),
        .o_idx    (pick_idx_s)
    );

    // Owner-driven outputs; reset masks them so a reset cycle can never complete a handshake.
    always_comb begin
        busy_s                = (state_q == ST_BUSY) && !i_rst;
        svc_valid_s           = busy_s && bus.i_req_valid[owner_q];
        handshake_s           = svc_valid_s && bus.i_svc_ready;
        bus.o_svc_valid       = svc_valid_s;
        bus.o_req_ready       = busy_s ? (owner_oh_s & {NUM_REQ{bus.i_svc_ready}}) : '0;
        bus.o_grant_onehot    = busy_s ? owner_oh_s : '0;
        bus.o_svc_wen_nren    = bus.i_req_wen_nren[owner_q];
        bus.o_svc_uncacheable = bus.i_req_uncacheable[owner_q];
        bus.o_svc_size        = bus.i_req_size[owner_q];
        bus.o_svc_addr        = bus.i_req_addr[owner_q];
        bus.o_svc_wdata       = bus.i_req_wdata[owner_q];
        bus.o_req_rdata       = bus.i_svc_rdata;
    end

    // Next-state: one picker serves the idle grant and the busy re-grant (finisher masked out).
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        pick_req_s   = bus.i_req_valid;
        pick_last_s  = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_d = ST_BUSY;
                    owner_d = pick_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                pick_req_s  = bus.i_req_valid & ~owner_oh_s;
                pick_last_s = owner_q;
                if (handshake_s) begin
                    last_grant_d = owner_q;
                    if (pick_valid_s) begin
                        owner_d = pick_idx_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!bus.i_req_valid[owner_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; last_grant resets to the top port so port 0 wins first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef SIMULATION
    letc_core_limp_arbiter_chk #(
        .NUM_REQ (NUM_REQ)
    ) u_chk (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_grant_onehot (bus.o_grant_onehot),
        .i_req_ready    (bus.o_req_ready),
        .i_svc_valid    (bus.o_svc_valid),
        .i_svc_ready    (bus.i_svc_ready),
        .i_payload      ({bus.o_svc_wen_nren, bus.o_svc_uncacheable, bus.o_svc_size,
                          bus.o_svc_addr, bus.o_svc_wdata})
    );
`endif

endmodule

// File: tb/tb_letc_core_limp_arbiter.sv
// Directed bench: a cycle table for a 2-port arbiter plus a 4-port rotation sequence.
module tb_letc_core_limp_arbiter;
    import letc_core_pkg::*;

    logic clk = 1'b0;
    logic rst2;
    logic rst4;
    always #5 clk = ~clk;

    letc_core_limp_arbiter_if #(.NUM_REQ(2)) bus2 ();
    letc_core_limp_arbiter_if #(.NUM_REQ(4)) bus4 ();

    letc_core_limp_arbiter #(.NUM_REQ(2)) dut2 (.i_clk(clk), .i_rst(rst2), .bus(bus2));
    letc_core_limp_arbiter #(.NUM_REQ(4)) dut4 (.i_clk(clk), .i_rst(rst4), .bus(bus4));

    typedef struct {
        logic       rst;
        logic [1:0] valid;
        logic       rdy;
        logic       esv;
        logic [1:0] erdy;
        logic [1:0] egnt;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic rst, input logic [1:0] valid, input logic rdy,
                                input logic esv, input logic [1:0] erdy, input logic [1:0] egnt);
        vec_t v;
        v.rst = rst; v.valid = valid; v.rdy = rdy; v.esv = esv; v.erdy = erdy; v.egnt = egnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    localparam logic [1:0] G0 = 2'b01;
    localparam logic [1:0] G1 = 2'b10;
    localparam logic [1:0] GN = 2'b00;

    int          seq_idx [5] = '{0, 2, 3, 0, 2};
    logic [3:0]  exp_g4;
    logic [33:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_wen;

    initial begin
        rst2 = 1'b1;
        rst4 = 1'b1;
        bus2.i_req_valid       = 2'b00;
        bus2.i_svc_ready       = 1'b0;
        bus2.i_svc_rdata       = 32'h0000_0000;
        bus2.i_req_wen_nren    = 2'b01;
        bus2.i_req_uncacheable = 2'b10;
        bus2.i_req_size[0]     = SIZE_WORD;
        bus2.i_req_size[1]     = SIZE_BYTE;
        bus2.i_req_addr[0]     = 34'h0000_0100;
        bus2.i_req_addr[1]     = 34'h0000_1000;
        bus2.i_req_wdata[0]    = 32'hA5A5_0000;
        bus2.i_req_wdata[1]    = 32'h5A5A_1111;
        bus4.i_req_valid       = 4'b0000;
        bus4.i_svc_ready       = 1'b0;
        bus4.i_svc_rdata       = 32'h0000_0000;
        bus4.i_req_wen_nren    = 4'b0000;
        bus4.i_req_uncacheable = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            bus4.i_req_size[i]  = SIZE_WORD;
            bus4.i_req_addr[i]  = 34'(i * 64);
            bus4.i_req_wdata[i] = 32'(i);
        end

        // Reset, lone port-1 read with two wait cycles, then return to idle.
        tbl.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, GN, GN));
        tbl.push_back(mk(1'b0, 2'b10, 1'b0, 1'b0, GN, GN));
        tbl.push_back(mk(1'b0, 2'b10, 1'b0, 1'b1, GN, G1));
        tbl.push_back(mk(1'b0, 2'b10, 1'b0, 1'b1, GN, G1));
        tbl.push_back(mk(1'b0, 2'b10, 1'b1, 1'b1, G1, G1));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, GN, GN));
        // Both ports valid: strict alternation with zero bubbles.
        tbl.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, GN, GN));
        tbl.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, G0, G0));
        tbl.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, G1, G1));
        tbl.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, G0, G0));
        tbl.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, G1, G1));
        // Locked transaction: downstream stalls five cycles, port 1 waiting.
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1'b0, 2'b11, 1'b0, 1'b1, GN, G0));
        tbl.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, G0, G0));
        // Reset while busy with ready high: no ready, and port 0 wins afterwards.
        tbl.push_back(mk(1'b1, 2'b11, 1'b1, 1'b0, GN, GN));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, GN, GN));
        tbl.push_back(mk(1'b0, 2'b11, 1'b0, 1'b0, GN, GN));
        tbl.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, G0, G0));
        tbl.push_back(mk(1'b0, 2'b10, 1'b1, 1'b1, G1, G1));
        // Port 0 alone back-to-back: one idle cycle between transactions.
        tbl.push_back(mk(1'b0, 2'b01, 1'b1, 1'b0, GN, GN));
        tbl.push_back(mk(1'b0, 2'b01, 1'b1, 1'b1, G0, G0));
        tbl.push_back(mk(1'b0, 2'b01, 1'b1, 1'b0, GN, GN));
        tbl.push_back(mk(1'b0, 2'b01, 1'b1, 1'b1, G0, G0));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, GN, GN));
        // Withdrawn request drops to idle without moving the rotation pointer.
        tbl.push_back(mk(1'b0, 2'b10, 1'b0, 1'b0, GN, GN));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, GN, G1));
        tbl.push_back(mk(1'b0, 2'b11, 1'b0, 1'b0, GN, GN));
        tbl.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, G1, G1));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, GN, G0));

        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clk);
            #1;
            rst2             = tbl[k].rst;
            bus2.i_req_valid = tbl[k].valid;
            bus2.i_svc_ready = tbl[k].rdy;
            bus2.i_svc_rdata = 32'hC0DE_0000 | 32'(k);
            @(negedge clk);
            check($sformatf("v%0d_svc_valid", k), 64'(bus2.o_svc_valid), 64'(tbl[k].esv));
            check($sformatf("v%0d_req_ready", k), 64'(bus2.o_req_ready), 64'(tbl[k].erdy));
            check($sformatf("v%0d_grant", k), 64'(bus2.o_grant_onehot), 64'(tbl[k].egnt));
            check($sformatf("v%0d_rdata", k), 64'(bus2.o_req_rdata), 64'(32'hC0DE_0000 | 32'(k)));
            if (tbl[k].esv) begin
                exp_addr  = (tbl[k].egnt == G1) ? 34'h0000_1000 : 34'h0000_0100;
                exp_wdata = (tbl[k].egnt == G1) ? 32'h5A5A_1111 : 32'hA5A5_0000;
                exp_wen   = (tbl[k].egnt == G0);
                check($sformatf("v%0d_svc_addr", k), 64'(bus2.o_svc_addr), 64'(exp_addr));
                check($sformatf("v%0d_svc_wdata", k), 64'(bus2.o_svc_wdata), 64'(exp_wdata));
                check($sformatf("v%0d_svc_wen", k), 64'(bus2.o_svc_wen_nren), 64'(exp_wen));
            end
        end

        // Four ports, 0/2/3 always valid and always accepted: rotation skips port 1.
        @(posedge clk);
        #1;
        rst4             = 1'b0;
        bus4.i_req_valid = 4'b1101;
        bus4.i_svc_ready = 1'b1;
        @(negedge clk);
        check("n4_idle_grant", 64'(bus4.o_grant_onehot), 64'(4'b0000));
        check("n4_idle_svc_valid", 64'(bus4.o_svc_valid), 64'(1'b0));
        for (int j = 0; j < 5; j++) begin
            @(posedge clk);
            #1;
            bus4.i_svc_rdata = 32'h0000_4000 | 32'(j);
            @(negedge clk);
            exp_g4 = 4'b0001 << seq_idx[j];
            check($sformatf("n4_t%0d_grant", j), 64'(bus4.o_grant_onehot), 64'(exp_g4));
            check($sformatf("n4_t%0d_ready", j), 64'(bus4.o_req_ready), 64'(exp_g4));
            check($sformatf("n4_t%0d_port1_ready", j), 64'(bus4.o_req_ready[1]), 64'(1'b0));
            check($sformatf("n4_t%0d_addr", j), 64'(bus4.o_svc_addr), 64'(seq_idx[j] * 64));
            check($sformatf("n4_t%0d_rdata", j), 64'(bus4.o_req_rdata), 64'(32'h0000_4000 | 32'(j)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/letc_core_limp_arbiter.md
LETC_CORE_LIMP_ARBITER -- requirements
Module: letc_core_limp_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, meaning the number of LIMP requestor ports (legal range 2..8).
REQ-002 SHALL have port i_clk, input, 1 bit: the single core clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset (fixed for this block).
REQ-004 SHALL have port i_req_valid, input, NUM_REQ bits: per-requestor LIMP valid.
REQ-005 SHALL have port o_req_ready, output, NUM_REQ bits: per-requestor LIMP ready.
REQ-006 SHALL have port i_req_wen_nren, input, NUM_REQ bits: per-requestor write, not read.
REQ-007 SHALL have port i_req_uncacheable, input, NUM_REQ bits: per-requestor uncacheable flag.
REQ-008 SHALL have port i_req_size, input, NUM_REQ x size_e: per-requestor access size.
REQ-009 SHALL have port i_req_addr, input, NUM_REQ x paddr_t: per-requestor physical address.
REQ-010 SHALL have port i_req_wdata, input, NUM_REQ x word_t: per-requestor write data.
REQ-011 SHALL have port o_req_rdata, output, word_t: read data broadcast to all requestors.
REQ-012 SHALL have ports o_svc_valid (out, 1), i_svc_ready (in, 1), o_svc_wen_nren (out, 1), o_svc_uncacheable (out, 1), o_svc_size (out, size_e), o_svc_addr (out, paddr_t), o_svc_wdata (out, word_t) and i_svc_rdata (in, word_t): the single downstream LIMP requestor port.
REQ-013 SHALL have port o_grant_onehot, output, NUM_REQ bits: current owner, for debug and performance counters.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (no owner) and BUSY (one registered owner).
REQ-015 IDLE: if i_req_valid is nonzero, SHALL register a grant to the first valid requestor in round-robin order, starting at last_grant+1 and wrapping at NUM_REQ-1 to 0, then enter BUSY; otherwise SHALL stay in IDLE.
REQ-016 Arbitration latency SHALL be exactly 1 cycle: o_svc_valid is never asserted in IDLE.
REQ-017 BUSY: o_svc_valid SHALL equal i_req_valid[owner], and all o_svc_* payload SHALL be muxed combinationally from the owner's inputs.
REQ-018 BUSY: o_req_ready[owner] SHALL equal i_svc_ready; every other o_req_ready bit SHALL be 0 in all states.
REQ-019 o_req_rdata SHALL equal i_svc_rdata in all states; requestors qualify it with their own ready.
REQ-020 BUSY, on handshake (o_svc_valid & i_svc_ready): SHALL set last_grant to the owner; if any other requestor is valid, SHALL re-grant directly (BUSY->BUSY, zero bubble) using round-robin from the new last_grant, excluding the finishing owner; otherwise SHALL go to IDLE.
REQ-021 BUSY with i_req_valid[owner]=0 (requestor withdrew before any transfer, which is illegal per LIMP, or bubble) SHALL return to IDLE without updating last_grant.
REQ-022 A grant SHALL never change while o_svc_valid=1 and i_svc_ready=0 (the transaction is locked).
REQ-023 Simultaneous requests from all ports SHALL be served in strict rotation; no requestor waits more than NUM_REQ-1 transactions.
REQ-024 o_grant_onehot SHALL be all zeros in IDLE and one-hot of the owner in BUSY.

Reset
REQ-025 When i_rst=1 at a clock edge: state SHALL become IDLE and last_grant SHALL become NUM_REQ-1, so port 0 has priority first.
REQ-026 While in reset state, o_svc_valid, o_req_ready and o_grant_onehot SHALL all be 0.
REQ-027 Reset mid-transaction SHALL abandon the grant with no further handshake; reset dominates a simultaneous handshake.

Structure
REQ-028 size_e, paddr_t and word_t SHALL come from letc_pkg / letc_core_pkg; the FSM state enum SHALL be local to the module.
REQ-029 The round-robin pick (request vector + last_grant -> one-hot or none) SHALL be a sub-module, letc_core_rr_picker, reused for both the IDLE grant and the BUSY re-grant.
REQ-030 Under SIMULATION, assertions SHALL check: grant is one-hot or zero; no ready is asserted to a non-owner; payload is stable while valid & !ready.

Verification
REQ-031 Reset, then only port 1 valid (read, addr 0x1000): grant at cycle +1, o_svc_addr=0x1000; ready after 2 cycles -> o_req_ready=2'b10 for one cycle, FSM returns to IDLE.
REQ-032 Both ports valid from reset: order is port0, port1, port0, port1 with zero idle cycles between handshakes.
REQ-033 i_svc_ready held low for 5 cycles with port0 owning and port1 valid: grant stays port0 and o_svc payload is unchanged throughout.
REQ-034 i_rst asserted in BUSY while i_svc_ready=1: next cycle IDLE, no ready pulse, last_grant=NUM_REQ-1.
REQ-035 NUM_REQ=4, ports 0, 2 and 3 continuously valid: grant sequence 0, 2, 3, 0, and port 1 never receives ready.
REQ-036 Port 0 sole requestor issuing back-to-back: handshake, IDLE for one cycle, then re-granted; o_req_rdata tracks i_svc_rdata every cycle.
